// File: rtl/laser_frame_tx.sv
// Serial laser framer: preamble, start bit, MSB-first payload and stop bit, each bit held CLK_PER_BIT clocks.
// tx changes on the request edge itself; requests arriving while busy are dropped, and the done cycle can accept the next frame.
module laser_frame_tx #(
    parameter int CLK_PER_BIT   = 54166,
    parameter int PKT_LENGTH    = 288,
    parameter int PREAMBLE_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PKT_LENGTH-1:0] data,
    input  logic                  new_data,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int CW   = $clog2(CLK_PER_BIT);
    localparam int BMAX = (PKT_LENGTH > PREAMBLE_BITS) ? PKT_LENGTH : PREAMBLE_BITS;
    localparam int BW   = $clog2(BMAX + 1);

    localparam logic [CW-1:0] C_LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [BW-1:0] P_LAST = BW'(PREAMBLE_BITS - 1);
    localparam logic [BW-1:0] D_LAST = BW'(PKT_LENGTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                  r_state;
    logic [CW-1:0]           r_clk_cnt;
    logic [BW-1:0]           r_bit_cnt;
    logic [PKT_LENGTH-1:0]   r_shift;
    logic                    r_tx;
    logic                    r_busy;
    logic                    r_done;

    state_t                  w_state_nxt;
    logic [CW-1:0]           w_clk_cnt_nxt;
    logic [BW-1:0]           w_bit_cnt_nxt;
    logic [PKT_LENGTH-1:0]   w_shift_nxt;
    logic                    w_tx_nxt;
    logic                    w_busy_nxt;
    logic                    w_done_nxt;
    logic                    w_bit_end;

    assign w_bit_end = (r_clk_cnt == C_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clk_cnt <= w_clk_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clk_cnt_nxt = r_clk_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        if (r_state == S_IDLE) begin
            w_clk_cnt_nxt = '0;
            w_bit_cnt_nxt = '0;
            if (new_data) begin
                w_state_nxt = S_PREAMBLE;
                w_shift_nxt = data;
            end
        end else if (!w_bit_end) begin
            w_clk_cnt_nxt = r_clk_cnt + 1'b1;
        end else begin
            w_clk_cnt_nxt = '0;
            case (r_state)
                S_PREAMBLE: begin
                    if (r_bit_cnt == P_LAST) begin
                        w_state_nxt   = S_START;
                        w_bit_cnt_nxt = '0;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end
                S_START: begin
                    w_state_nxt   = S_DATA;
                    w_bit_cnt_nxt = '0;
                end
                S_DATA: begin
                    w_shift_nxt = r_shift << 1;
                    if (r_bit_cnt == D_LAST) begin
                        w_state_nxt   = S_STOP;
                        w_bit_cnt_nxt = '0;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt   = S_IDLE;
                    w_bit_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Outputs are precomputed from the next state so every pin comes straight off a flop.
    always_comb begin
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (r_state == S_STOP) && w_bit_end;
        case (w_state_nxt)
            S_PREAMBLE: w_tx_nxt = ~w_bit_cnt_nxt[0];
            S_START:    w_tx_nxt = 1'b0;
            S_DATA:     w_tx_nxt = w_shift_nxt[PKT_LENGTH-1];
            default:    w_tx_nxt = 1'b1;
        endcase
    end

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_laser_frame_tx.sv
// Scoreboarded bench: expected payloads are queued at request time and compared against frames decoded from tx.
module tb_laser_frame_tx;

    localparam int CPB = 4;
    localparam int L   = 8;
    localparam int P   = 4;
    localparam int F   = P + L + 2;
    localparam int FC  = F * CPB;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         new_data = 1'b0;
    logic [L-1:0] data = '0;
    logic         tx;
    logic         busy;
    logic         done;

    laser_frame_tx #(
        .CLK_PER_BIT  (CPB),
        .PKT_LENGTH   (L),
        .PREAMBLE_BITS(P)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data    (data),
        .new_data(new_data),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int           n_chk = 0;
    int           n_fail = 0;
    int           n_done = 0;
    longint       cyc = 0;
    logic [L-1:0] exp_q[$];
    longint       done_cyc_q[$];

    int           s_cnt = 0;
    logic [F-1:0] obs = '0;
    logic         hold_err = 1'b0;
    logic         last_bit = 1'b1;
    logic [L-1:0] pl;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [F-1:0] exp_frame(input logic [L-1:0] payload);
        logic [F-1:0] f;
        f = '0;
        for (int i = 0; i < P; i++) f[F-1-i] = (i % 2 == 0);
        f[F-1-P] = 1'b0;
        f[L:1]   = payload;
        f[0]     = 1'b1;
        return f;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_dones(input int target, input int limit);
        for (int i = 0; i < limit && n_done < target; i++) @(posedge clk);
        #1;
        chk("done_timeout", 64'(n_done >= target), 64'd1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Decode the tx waveform one cycle at a time, half a clock away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            s_cnt    = 0;
            obs      = '0;
            hold_err = 1'b0;
        end else begin
            if (busy) begin
                if (s_cnt < FC) begin
                    if (s_cnt % CPB == 0) begin
                        obs      = {obs[F-2:0], tx};
                        last_bit = tx;
                    end else if (tx !== last_bit) begin
                        hold_err = 1'b1;
                    end
                end
                s_cnt++;
            end
            if (done) begin
                n_done++;
                done_cyc_q.push_back(cyc);
                chk("done_busy_excl", 64'(busy), 64'd0);
                chk("tx_idle_at_done", 64'(tx), 64'd1);
                chk("frame_cycles", 64'(s_cnt), 64'(FC));
                chk("bit_hold", 64'(hold_err), 64'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 64'd1, 64'd0);
                end else begin
                    pl = exp_q.pop_front();
                    chk("frame_bits", 64'(obs), 64'(exp_frame(pl)));
                end
                s_cnt    = 0;
                obs      = '0;
                hold_err = 1'b0;
            end
        end
    end

    initial begin
        int base;
        #12;
        chk("rst_tx", 64'(tx), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // single frame
        tick(2);
        data = 8'hA5; new_data = 1'b1; exp_q.push_back(8'hA5);
        tick(1);
        new_data = 1'b0;
        chk("busy_on_accept", 64'(busy), 64'd1);
        chk("tx_first_preamble", 64'(tx), 64'd1);
        wait_dones(1, 200);
        tick(20);
        chk("single_done_count", 64'(n_done), 64'd1);
        chk("idle_tx", 64'(tx), 64'd1);

        // requests while busy are dropped
        data = 8'hFF; new_data = 1'b1; exp_q.push_back(8'hFF);
        tick(1);
        new_data = 1'b0;
        tick(10);
        data = 8'h00; new_data = 1'b1;
        tick(20);
        new_data = 1'b0;
        wait_dones(2, 200);
        tick(20);
        chk("ignore_done_count", 64'(n_done), 64'd2);

        // back-to-back frames with new_data held high
        base = done_cyc_q.size();
        data = 8'h3C; new_data = 1'b1;
        repeat (3) exp_q.push_back(8'h3C);
        tick(1);
        tick(114);
        new_data = 1'b0;
        wait_dones(5, 400);
        tick(80);
        chk("b2b_done_count", 64'(n_done), 64'd5);
        if (done_cyc_q.size() >= base + 3) begin
            chk("b2b_gap1", 64'(done_cyc_q[base+1] - done_cyc_q[base]), 64'd57);
            chk("b2b_gap2", 64'(done_cyc_q[base+2] - done_cyc_q[base+1]), 64'd57);
        end else begin
            chk("b2b_gap_missing", 64'(done_cyc_q.size()), 64'(base + 3));
        end

        // asynchronous reset during payload bit 3
        data = 8'h5A; new_data = 1'b1;
        tick(1);
        new_data = 1'b0;
        tick(33);
        chk("busy_before_abort", 64'(busy), 64'd1);
        #3 rst = 1'b1;
        #1;
        chk("abort_tx", 64'(tx), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick(60);
        chk("abort_no_done", 64'(n_done), 64'd5);
        data = 8'h81; new_data = 1'b1; exp_q.push_back(8'h81);
        tick(1);
        new_data = 1'b0;
        wait_dones(6, 200);
        tick(5);
        chk("final_done_count", 64'(n_done), 64'd6);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/laser_frame_tx.md
LASER_FRAME_TX -- requirements
Module: laser_frame_tx

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 54166: clock cycles per transmitted bit (1200 baud at 65 MHz); legal range >= 2.
REQ-002 SHALL have parameter PKT_LENGTH, default 288: payload bits per frame (32*9).
REQ-003 SHALL have parameter PREAMBLE_BITS, default 8: number of alternating sync bits sent before the start bit; legal range >= 1.
REQ-004 SHALL have one clock; reset is asynchronous and active-high (ports clk, rst).
REQ-005 clk  input  1  system clock (65 MHz).
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 data  input  PKT_LENGTH  packet from packet generator; sampled only on acceptance.
REQ-008 new_data  input  1  request to transmit data; level-sampled each clk edge.
REQ-009 tx  output  1  laser drive, registered; idle level 1.
REQ-010 busy  output  1  high while a frame is in flight.
REQ-011 done  output  1  one-cycle pulse at frame completion.

Function
REQ-012 SHALL implement states IDLE, PREAMBLE, START, DATA, STOP.
REQ-013 Frame order SHALL be: PREAMBLE_BITS bits 1,0,1,0,... (first bit 1); start bit 0; PKT_LENGTH payload bits, data[PKT_LENGTH-1] first (MSB-first); one stop bit 1.
REQ-014 Every frame bit SHALL be held on tx for exactly CLK_PER_BIT cycles, timed by a cycle counter cleared at each bit boundary.
REQ-015 Frame duration SHALL be exactly (PREAMBLE_BITS+PKT_LENGTH+2)*CLK_PER_BIT cycles.
REQ-016 Acceptance: new_data=1 while in IDLE at edge N -> data copied into an internal shift register, state=PREAMBLE, busy=1 and tx=first preamble bit from edge N.
REQ-017 new_data while busy=1 SHALL be ignored; the shift register SHALL NOT change; no request is queued.
REQ-018 Changes on data after acceptance SHALL NOT affect the frame in flight.
REQ-019 Payload bit counter SHALL be wide enough for PKT_LENGTH (9 bits at default) and SHALL NOT wrap within a frame.
REQ-020 On completion of the stop bit's last cycle: state=IDLE, busy=0, tx=1, done=1 for exactly that one cycle.
REQ-021 new_data=1 during the done cycle SHALL be accepted (back-to-back frames; no idle gap beyond that cycle).
REQ-022 done SHALL be 0 in every cycle except REQ-020; busy and done SHALL never both be 1.
REQ-023 tx SHALL be glitch-free (driven from a flop), 1 in IDLE.

Reset
REQ-024 While rst=1 (asynchronously): state=IDLE, tx=1, busy=0, done=0, counters=0, shift register=0.
REQ-025 rst mid-frame SHALL abort the frame with no done pulse; first new_data after rst deasserts starts a fresh frame from the first preamble bit.

Verification (CLK_PER_BIT=4, PKT_LENGTH=8, PREAMBLE_BITS=4 unless noted)
REQ-026 Single frame: data=8'hA5, new_data pulse 1 cycle -> tx = 1,0,1,0,0,1,0,1,0,0,1,0,1,1 each held 4 cycles, busy high 56 cycles, done pulse once at cycle 57, tx=1 after.
REQ-027 Busy ignore: data=8'hFF accepted, then new_data=1 with data=8'h00 held for 20 cycles mid-frame -> payload on tx remains 8'hFF, only one done.
REQ-028 Back-to-back: new_data held high continuously with data=8'h3C -> frames repeat with exactly one-cycle spacing (done cycle), each frame 56 busy cycles, payload 8'h3C.
REQ-029 Reset mid-frame: assert rst during payload bit 3 -> tx=1, busy=0 within same cycle (async), no done; after release, data=8'h81 frame transmits correctly.
REQ-030 Default parameters: PKT_LENGTH=288, CLK_PER_BIT=54166, alternating payload -> busy high exactly 298*54166 = 16,141,468 cycles, bit edges every 54166 cycles.
